// File: rtl/ysyx_23060191_wbu_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060191_wbu_pkg
// Shared definitions for the write-back unit: datapath width, FSM state
// encodings and the RISC-V load funct3 codes understood by the load
// extractor.
// ---------------------------------------------------------------------------
package ysyx_23060191_wbu_pkg;

  localparam int CPU_WIDTH = 32;

  typedef enum logic [1:0] {
    WBU_IDLE     = 2'd0,
    WBU_WAIT_MEM = 2'd1,
    WBU_COMMIT   = 2'd2
  } wbu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/ysyx_23060191_load_ext.sv
// ---------------------------------------------------------------------------
// ysyx_23060191_load_ext
// Combinational load-data extractor. Selects the byte/half addressed by the
// low address bits out of an aligned memory word and sign- or zero-extends
// it according to the load funct3. Unknown funct3 codes pass the raw word.
//
// Ports:
//   i_funct3  [2:0]  load funct3
//   i_addr_lo [1:0]  load address bits [1:0]
//   i_rdata   [W-1:0] raw aligned memory word
//   o_data    [W-1:0] extracted / extended value
// ---------------------------------------------------------------------------
module ysyx_23060191_load_ext
  import ysyx_23060191_wbu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [2:0]   i_funct3,
  input  logic [1:0]   i_addr_lo,
  input  logic [W-1:0] i_rdata,
  output logic [W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection: byte by full addr_lo, half by addr_lo[1] only.
  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    if (i_addr_lo[1]) begin
      w_half = i_rdata[31:16];
    end else begin
      w_half = i_rdata[15:0];
    end
  end

  // Extension by load type; unsupported codes return the word untouched.
  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_LB:   o_data = {{(W-8){w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {{(W-8){1'b0}}, w_byte};
      F3_LH:   o_data = {{(W-16){w_half[15]}}, w_half};
      F3_LHU:  o_data = {{(W-16){1'b0}}, w_half};
      F3_LW:   o_data = i_rdata;
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_23060191_wbu.sv
// ---------------------------------------------------------------------------
// ysyx_23060191_wbu
// Write-back unit in front of the GPR file. Accepts completed instructions
// over valid/ready, waits for the memory response on loads, extracts the
// load data, then drives the GPR write port and a one-cycle commit pulse
// for difftest. ALU results commit the cycle after transfer (1/cycle).
//
// Optional build macro: WBU_MEM_TIMEOUT_EN adds a sticky timeout_err output
// raised when a load waits TIMEOUT_CYCLES cycles without a response.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid / in_ready        upstream handshake (ready from state only)
//   in_pc, in_rd_we, in_rd     instruction PC, rd write flag, rd index
//   in_result                  non-load result
//   in_is_load, in_ld_funct3,
//   in_addr_lo                 load descriptor
//   mem_rvalid, mem_rdata      memory read response
//   wr_en_Rd, addr_Rd, data_Rd GPR write port (registered)
//   commit_valid, commit_pc    commit pulse and PC (registered)
//   timeout_err                sticky load timeout (WBU_MEM_TIMEOUT_EN only)
// ---------------------------------------------------------------------------
module ysyx_23060191_wbu
  import ysyx_23060191_wbu_pkg::*;
#(
  parameter int CPU_WIDTH = ysyx_23060191_wbu_pkg::CPU_WIDTH
`ifdef WBU_MEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CPU_WIDTH-1:0] in_pc,
  input  logic                 in_rd_we,
  input  logic [4:0]           in_rd,
  input  logic [CPU_WIDTH-1:0] in_result,
  input  logic                 in_is_load,
  input  logic [2:0]           in_ld_funct3,
  input  logic [1:0]           in_addr_lo,
  input  logic                 mem_rvalid,
  input  logic [CPU_WIDTH-1:0] mem_rdata,
`ifdef WBU_MEM_TIMEOUT_EN
  output logic                 timeout_err,
`endif
  output logic                 wr_en_Rd,
  output logic [4:0]           addr_Rd,
  output logic [CPU_WIDTH-1:0] data_Rd,
  output logic                 commit_valid,
  output logic [CPU_WIDTH-1:0] commit_pc
);

  wbu_state_e r_state;
  wbu_state_e w_state_nxt;

  logic                 w_ready;
  logic                 w_xfer;
  logic                 w_load_done;
  logic [CPU_WIDTH-1:0] w_ext_data;

  // Instruction fields held while a load waits for memory.
  logic [CPU_WIDTH-1:0] r_pc;
  logic                 r_rd_we;
  logic [4:0]           r_rd;
  logic [2:0]           r_funct3;
  logic [1:0]           r_addr_lo;

  // Output registers; data register doubles as the committed result.
  logic                 r_wr_en;
  logic [4:0]           r_addr;
  logic [CPU_WIDTH-1:0] r_data;
  logic                 r_commit_valid;
  logic [CPU_WIDTH-1:0] r_commit_pc;

  assign w_ready     = (r_state == WBU_IDLE) || (r_state == WBU_COMMIT);
  assign w_xfer      = in_valid && w_ready;
  // A response is only meaningful while a load is actually outstanding.
  assign w_load_done = (r_state == WBU_WAIT_MEM) && mem_rvalid;

  ysyx_23060191_load_ext #(
    .W (CPU_WIDTH)
  ) u_load_ext (
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr_lo),
    .i_rdata   (mem_rdata),
    .o_data    (w_ext_data)
  );

  // Next-state logic; COMMIT behaves like IDLE for accepting a new transfer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WBU_IDLE, WBU_COMMIT: begin
        if (w_xfer) begin
          if (in_is_load) begin
            w_state_nxt = WBU_WAIT_MEM;
          end else begin
            w_state_nxt = WBU_COMMIT;
          end
        end else begin
          w_state_nxt = WBU_IDLE;
        end
      end
      WBU_WAIT_MEM: begin
        if (mem_rvalid) begin
          w_state_nxt = WBU_COMMIT;
        end else begin
          w_state_nxt = WBU_WAIT_MEM;
        end
      end
      default: w_state_nxt = WBU_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= WBU_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the accepted instruction's fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= '0;
      r_rd_we   <= 1'b0;
      r_rd      <= 5'd0;
      r_funct3  <= 3'd0;
      r_addr_lo <= 2'd0;
    end else if (w_xfer) begin
      r_pc      <= in_pc;
      r_rd_we   <= in_rd_we;
      r_rd      <= in_rd;
      r_funct3  <= in_ld_funct3;
      r_addr_lo <= in_addr_lo;
    end
  end

  // Output registers are loaded on the edge that enters COMMIT, so they are
  // valid exactly during the COMMIT cycle; index/data/pc hold afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en        <= 1'b0;
      r_addr         <= 5'd0;
      r_data         <= '0;
      r_commit_valid <= 1'b0;
      r_commit_pc    <= '0;
    end else begin
      r_wr_en        <= 1'b0;
      r_commit_valid <= 1'b0;
      if (w_load_done) begin
        r_wr_en        <= r_rd_we && (r_rd != 5'd0);
        r_addr         <= r_rd;
        r_data         <= w_ext_data;
        r_commit_valid <= 1'b1;
        r_commit_pc    <= r_pc;
      end else if (w_xfer && !in_is_load) begin
        r_wr_en        <= in_rd_we && (in_rd != 5'd0);
        r_addr         <= in_rd;
        r_data         <= in_result;
        r_commit_valid <= 1'b1;
        r_commit_pc    <= in_pc;
      end
    end
  end

  assign in_ready     = w_ready;
  assign wr_en_Rd     = r_wr_en;
  assign addr_Rd      = r_addr;
  assign data_Rd      = r_data;
  assign commit_valid = r_commit_valid;
  assign commit_pc    = r_commit_pc;

`ifdef WBU_MEM_TIMEOUT_EN
  logic [7:0] r_wait_cnt;
  logic       r_timeout_err;

  // Load-response watchdog: counter saturates, error is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt    <= 8'd0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_xfer && in_is_load) begin
        r_wait_cnt <= 8'd0;
      end else if ((r_state == WBU_WAIT_MEM) && !mem_rvalid && (r_wait_cnt != 8'hFF)) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
      if ((r_state == WBU_WAIT_MEM) && (r_wait_cnt == 8'(TIMEOUT_CYCLES))) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`endif

endmodule

// File: tb/tb_ysyx_23060191_wbu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060191_wbu
// Self-checking bench for the write-back unit: directed scenarios followed
// by randomized traffic, compared against a transaction-level model that
// tracks only "is a load outstanding" and the expected commit per cycle.
// ---------------------------------------------------------------------------
module tb_ysyx_23060191_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic        in_rd_we;
  logic [4:0]  in_rd;
  logic [31:0] in_result;
  logic        in_is_load;
  logic [2:0]  in_ld_funct3;
  logic [1:0]  in_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wr_en_Rd;
  logic [4:0]  addr_Rd;
  logic [31:0] data_Rd;
  logic        commit_valid;
  logic [31:0] commit_pc;
`ifdef WBU_MEM_TIMEOUT_EN
  logic        timeout_err;
`endif

  int checks;
  int failures;

  // Model state: one outstanding load at most, plus last committed values.
  bit          m_pending;
  logic [31:0] p_pc;
  logic        p_we;
  logic [4:0]  p_rd;
  logic [2:0]  p_f3;
  logic [1:0]  p_lo;
  logic [31:0] m_last_pc;
  logic [4:0]  m_last_rd;
  logic [31:0] m_last_data;

  always #5 clk = ~clk;

  ysyx_23060191_wbu dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_rd_we     (in_rd_we),
    .in_rd        (in_rd),
    .in_result    (in_result),
    .in_is_load   (in_is_load),
    .in_ld_funct3 (in_ld_funct3),
    .in_addr_lo   (in_addr_lo),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
`ifdef WBU_MEM_TIMEOUT_EN
    .timeout_err  (timeout_err),
`endif
    .wr_en_Rd     (wr_en_Rd),
    .addr_Rd      (addr_Rd),
    .data_Rd      (data_Rd),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference load extraction using shifts and masks on the whole word.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * lo)) & 32'h0000_00FF;
    h = (w >> (16 * (lo / 2))) & 32'h0000_FFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic m_reset();
    m_pending   = 1'b0;
    m_last_pc   = 32'd0;
    m_last_rd   = 5'd0;
    m_last_data = 32'd0;
  endtask

  // One clock: drive inputs (called at posedge+1), predict, step, compare.
  task automatic do_cycle(input logic v, input logic [31:0] pc, input logic we,
                          input logic [4:0] rd, input logic [31:0] res, input logic ld,
                          input logic [2:0] f3, input logic [1:0] lo,
                          input logic rv, input logic [31:0] rdat);
    bit          have;
    logic        c_we;
    logic [4:0]  c_rd;
    logic [31:0] c_pc;
    logic [31:0] c_data;
    in_valid = v; in_pc = pc; in_rd_we = we; in_rd = rd; in_result = res;
    in_is_load = ld; in_ld_funct3 = f3; in_addr_lo = lo;
    mem_rvalid = rv; mem_rdata = rdat;
    chk("in_ready", in_ready, {31'd0, !m_pending});
    have = 1'b0; c_we = 1'b0; c_rd = 5'd0; c_pc = 32'd0; c_data = 32'd0;
    if (m_pending) begin
      if (rv) begin
        have = 1'b1; c_we = p_we; c_rd = p_rd; c_pc = p_pc;
        c_data = ref_load(p_f3, p_lo, rdat);
        m_pending = 1'b0;
      end
    end else if (v) begin
      if (ld) begin
        m_pending = 1'b1; p_pc = pc; p_we = we; p_rd = rd; p_f3 = f3; p_lo = lo;
      end else begin
        have = 1'b1; c_we = we; c_rd = rd; c_pc = pc; c_data = res;
      end
    end
    @(posedge clk);
    #1;
    chk("commit_valid", {31'd0, commit_valid}, {31'd0, have});
    if (have) begin
      m_last_pc = c_pc; m_last_rd = c_rd; m_last_data = c_data;
    end
    chk("wr_en_Rd", {31'd0, wr_en_Rd}, {31'd0, have && c_we && (c_rd != 5'd0)});
    chk("addr_Rd", {27'd0, addr_Rd}, {27'd0, m_last_rd});
    chk("data_Rd", data_Rd, m_last_data);
    chk("commit_pc", commit_pc, m_last_pc);
  endtask

  task automatic idle_cycle(input logic rv, input logic [31:0] rdat);
    do_cycle(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0, rv, rdat);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    in_valid = 1'b0; in_pc = 32'd0; in_rd_we = 1'b0; in_rd = 5'd0; in_result = 32'd0;
    in_is_load = 1'b0; in_ld_funct3 = 3'd0; in_addr_lo = 2'd0;
    mem_rvalid = 1'b0; mem_rdata = 32'd0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", {31'd0, wr_en_Rd}, 32'd0);
    chk("rst_addr", {27'd0, addr_Rd}, 32'd0);
    chk("rst_data", data_Rd, 32'd0);
    chk("rst_commit_valid", {31'd0, commit_valid}, 32'd0);
    chk("rst_commit_pc", commit_pc, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Single ALU op.
    do_cycle(1'b1, 32'h8000_0000, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 3'd0, 2'd0, 1'b0, 32'd0);
    chk("alu_wen", {31'd0, wr_en_Rd}, 32'd1);
    chk("alu_addr", {27'd0, addr_Rd}, 32'd5);
    chk("alu_data", data_Rd, 32'h1234_5678);
    idle_cycle(1'b0, 32'd0);

    // Back-to-back ALU ops with in_valid held.
    for (int i = 1; i <= 3; i++) begin
      do_cycle(1'b1, 32'h8000_0100 + 32'(4 * i), 1'b1, 5'(i), 32'hA000_0000 + 32'(i),
               1'b0, 3'd0, 2'd0, 1'b0, 32'd0);
    end
    chk("b2b_last_pc", commit_pc, 32'h8000_010C);
    idle_cycle(1'b0, 32'd0);

    // LB lane 3, response two cycles after transfer.
    do_cycle(1'b1, 32'h8000_0200, 1'b1, 5'd7, 32'd0, 1'b1, 3'b000, 2'd3, 1'b0, 32'd0);
    idle_cycle(1'b0, 32'd0);
    idle_cycle(1'b1, 32'h80FF_0000);
    chk("lb_data", data_Rd, 32'hFFFF_FF80);

    // LHU upper half, then LH lower half of the same word.
    do_cycle(1'b1, 32'h8000_0204, 1'b1, 5'd8, 32'd0, 1'b1, 3'b101, 2'd2, 1'b0, 32'd0);
    idle_cycle(1'b1, 32'h8001_7FFF);
    chk("lhu_data", data_Rd, 32'h0000_8001);
    do_cycle(1'b1, 32'h8000_0208, 1'b1, 5'd9, 32'd0, 1'b1, 3'b001, 2'd0, 1'b0, 32'd0);
    idle_cycle(1'b1, 32'h8001_7FFF);
    chk("lh_data", data_Rd, 32'h0000_7FFF);

    // rd = x0 still commits without a write.
    do_cycle(1'b1, 32'h8000_0300, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 3'd0, 2'd0, 1'b0, 32'd0);
    chk("x0_commit", {31'd0, commit_valid}, 32'd1);
    chk("x0_wen", {31'd0, wr_en_Rd}, 32'd0);

    // Reset while waiting for memory: load dropped, late response ignored.
    do_cycle(1'b1, 32'h8000_0400, 1'b1, 5'd10, 32'd0, 1'b1, 3'b010, 2'd0, 1'b0, 32'd0);
    idle_cycle(1'b0, 32'd0);
    rst = 1'b1;
    m_reset();
    #2;
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_commit", {31'd0, commit_valid}, 32'd0);
    chk("midrst_data", data_Rd, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle_cycle(1'b1, 32'h5555_AAAA);
    chk("late_rvalid_ready", {31'd0, in_ready}, 32'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      do_cycle($urandom_range(0, 3) != 0, $urandom, 1'($urandom), 5'($urandom),
               $urandom, $urandom_range(0, 2) == 0, 3'($urandom), 2'($urandom),
               1'($urandom), $urandom);
    end
    idle_cycle(1'b1, $urandom);
    idle_cycle(1'b0, 32'd0);

`ifdef WBU_MEM_TIMEOUT_EN
    chk("to_clear", {31'd0, timeout_err}, 32'd0);
    do_cycle(1'b1, 32'h8000_0500, 1'b1, 5'd11, 32'd0, 1'b1, 3'b010, 2'd0, 1'b0, 32'd0);
    for (int k = 0; k < 10; k++) idle_cycle(1'b0, 32'd0);
    chk("to_early", {31'd0, timeout_err}, 32'd0);
    for (int k = 0; k < 280; k++) idle_cycle(1'b0, 32'd0);
    chk("to_set", {31'd0, timeout_err}, 32'd1);
    idle_cycle(1'b1, 32'hCAFE_F00D);
    chk("to_late_data", data_Rd, 32'hCAFE_F00D);
    idle_cycle(1'b0, 32'd0);
    chk("to_sticky", {31'd0, timeout_err}, 32'd1);
    rst = 1'b1;
    m_reset();
    #2;
    chk("to_rst", {31'd0, timeout_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
